// File: rtl/char_cell_renderer.sv
// Renders one ASCII character into a 6x12 text cell of a 1-bpp framebuffer,
// fetching one glyph ROM pixel per cycle and writing it one cycle later.
module char_cell_renderer #(
  parameter int DISP_W  = 128,
  parameter int DISP_H  = 64,
  parameter int GLYPH_W = 5,
  parameter int GLYPH_H = 12,
  parameter int CELL_W  = 6,
  parameter int CELL_H  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        char_valid,
  output logic        char_ready,
  input  logic [7:0]  char_in,
  input  logic [4:0]  col,
  input  logic [2:0]  row,
  input  logic        invert,
  output logic [7:0]  rom_char,
  output logic [5:0]  rom_pos,
  input  logic        rom_pixel,
  output logic        fb_we,
  output logic [12:0] fb_addr,
  output logic        fb_data,
  output logic        busy,
  output logic        done
);

  localparam int TEXT_COLS = DISP_W / CELL_W;
  localparam int TEXT_ROWS = DISP_H / CELL_H;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  char_q, char_d;
  logic [4:0]  col_q, col_d;
  logic [2:0]  row_q, row_d;
  logic        inv_q, inv_d;
  logic        drop_q, drop_d;
  logic [2:0]  px_q, px_d;
  logic [3:0]  py_q, py_d;
  logic        fb_we_q, fb_we_d;
  logic [12:0] fb_addr_q, fb_addr_d;
  logic        fb_data_q, fb_data_d;
  logic        done_q, done_d;

  logic        in_glyph;
  logic        last_col;
  logic        last_row;
  logic [5:0]  glyph_idx;
  logic [12:0] pix_x;
  logic [12:0] pix_y;
  logic [12:0] pix_addr;
  logic        pix_val;

  // Pixel geometry for the current (px, py) position inside the cell.
  always_comb begin
    in_glyph  = (px_q < 3'(GLYPH_W)) && (py_q < 4'(GLYPH_H));
    last_col  = (px_q == 3'(CELL_W - 1));
    last_row  = (py_q == 4'(CELL_H - 1));
    glyph_idx = 6'(py_q) * 6'(GLYPH_W) + 6'(px_q);
    pix_x     = 13'(col_q) * 13'(CELL_W) + 13'(px_q);
    pix_y     = 13'(row_q) * 13'(CELL_H) + 13'(py_q);
    pix_addr  = pix_y * 13'(DISP_W) + pix_x;
    pix_val   = (in_glyph ? rom_pixel : 1'b0) ^ inv_q;
  end

  always_comb begin
    state_d   = state_q;
    char_d    = char_q;
    col_d     = col_q;
    row_d     = row_q;
    inv_d     = inv_q;
    drop_d    = drop_q;
    px_d      = px_q;
    py_d      = py_q;
    fb_we_d   = 1'b0;
    fb_addr_d = fb_addr_q;
    fb_data_d = fb_data_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (char_valid) begin
          char_d  = char_in;
          col_d   = col;
          row_d   = row;
          inv_d   = invert;
          px_d    = 3'd0;
          py_d    = 4'd0;
          drop_d  = (col >= 5'(TEXT_COLS)) || (row >= 3'(TEXT_ROWS));
          state_d = DRAW;
        end
      end

      DRAW: begin
        // A dropped cell keeps its timing but leaves the framebuffer bus untouched.
        fb_we_d = !drop_q;
        if (!drop_q) begin
          fb_addr_d = pix_addr;
          fb_data_d = pix_val;
        end
        if (last_col) begin
          px_d = 3'd0;
          if (last_row) begin
            state_d = FIN;
          end else begin
            py_d = py_q + 4'd1;
          end
        end else begin
          px_d = px_q + 3'd1;
        end
      end

      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      char_q    <= 8'd0;
      col_q     <= 5'd0;
      row_q     <= 3'd0;
      inv_q     <= 1'b0;
      drop_q    <= 1'b0;
      px_q      <= 3'd0;
      py_q      <= 4'd0;
      fb_we_q   <= 1'b0;
      fb_addr_q <= 13'd0;
      fb_data_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      char_q    <= char_d;
      col_q     <= col_d;
      row_q     <= row_d;
      inv_q     <= inv_d;
      drop_q    <= drop_d;
      px_q      <= px_d;
      py_q      <= py_d;
      fb_we_q   <= fb_we_d;
      fb_addr_q <= fb_addr_d;
      fb_data_q <= fb_data_d;
      done_q    <= done_d;
    end
  end

  // The ROM address is combinational so its pixel lands in the next write.
  assign rom_char   = char_q;
  assign rom_pos    = (state_q == DRAW && in_glyph) ? glyph_idx : 6'd0;
  assign char_ready = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign fb_we      = fb_we_q;
  assign fb_addr    = fb_addr_q;
  assign fb_data    = fb_data_q;
  assign done       = done_q;

endmodule

// File: tb/tb_char_cell_renderer.sv
// Self-checking bench for char_cell_renderer: table vectors, random cells
// against a pixel-list reference model, back-to-back and mid-render reset.
module tb_char_cell_renderer;

  logic        clk;
  logic        rst_n;
  logic        char_valid;
  logic        char_ready;
  logic [7:0]  char_in;
  logic [4:0]  col_in;
  logic [2:0]  row_in;
  logic        inv_in;
  logic [7:0]  rom_char;
  logic [5:0]  rom_pos;
  logic        rom_pixel;
  logic        fb_we;
  logic [12:0] fb_addr;
  logic        fb_data;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  char_cell_renderer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_in    (char_in),
    .col        (col_in),
    .row        (row_in),
    .invert     (inv_in),
    .rom_char   (rom_char),
    .rom_pos    (rom_pos),
    .rom_pixel  (rom_pixel),
    .fb_we      (fb_we),
    .fb_addr    (fb_addr),
    .fb_data    (fb_data),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in glyph ROM: arbitrary printable patterns, blank for space and non-printables.
  function automatic logic glyph_bit(input logic [7:0] c, input logic [5:0] pos);
    int v;
    if (c < 8'd33 || c > 8'd126 || pos > 6'd59) return 1'b0;
    v = int'(c) * 31 + int'(pos) * 17 + int'(pos) * int'(pos);
    return (v % 7) < 3;
  endfunction

  assign rom_pixel = glyph_bit(rom_char, rom_pos);

  typedef struct {
    int   addr;
    logic data;
  } wr_t;

  typedef struct {
    logic [7:0] c;
    logic [4:0] col;
    logic [2:0] row;
    logic       inv;
    int         exp_count;
    int         exp_first;
    int         exp_last;
    int         exp_ones;
  } vec_t;

  task automatic checkOutput(input string name, input int actual, input int expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: actual %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] c, input logic [4:0] col, input logic [2:0] row,
                               input logic inv);
    int w;
    w = 0;
    while (!char_ready && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    checkOutput("ready_before_request", char_ready, 1);
    char_valid = 1'b1;
    char_in    = c;
    col_in     = col;
    row_in     = row;
    inv_in     = inv;
  endtask

  // Watches one cell from its accept edge (k=0) through DONE, checking timing
  // every cycle and each write against the model's pixel list.
  task automatic captureCell(input logic [7:0] c, input logic [4:0] col, input logic [2:0] row,
                             input logic inv, input bit hold, input logic [7:0] new_c,
                             input logic [4:0] new_col, output int n_wr, output int first_addr,
                             output int last_addr, output int n_ones);
    wr_t exp_q[$];
    bit  drop;
    int  lim;
    drop = (col > 5'd20) || (row > 3'd4);
    if (!drop) begin
      for (int py = 0; py < 12; py++) begin
        for (int px = 0; px < 6; px++) begin
          wr_t w;
          w.addr = (int'(row) * 12 + py) * 128 + int'(col) * 6 + px;
          w.data = ((px < 5) ? glyph_bit(c, 6'(py * 5 + px)) : 1'b0) ^ inv;
          exp_q.push_back(w);
        end
      end
    end
    n_wr = 0;
    n_ones = 0;
    first_addr = -1;
    last_addr = -1;
    lim = hold ? 73 : 74;
    for (int k = 0; k <= lim; k++) begin
      @(posedge clk);
      #1;
      if (k == 0 && !hold) begin
        char_valid = 1'b0;
        char_in    = 8'($urandom);
        col_in     = 5'($urandom);
        row_in     = 3'($urandom);
        inv_in     = 1'($urandom);
      end
      if (hold && k == 10) begin
        char_in = new_c;
        col_in  = new_col;
      end
      checkOutput("fb_we", fb_we, (k >= 1 && k <= 72 && !drop) ? 1 : 0);
      checkOutput("busy", busy, (k <= 72) ? 1 : 0);
      checkOutput("char_ready", char_ready, (k >= 73) ? 1 : 0);
      checkOutput("done", done, (k == 73) ? 1 : 0);
      if (k == 20) checkOutput("rom_char", rom_char, c);
      if (k >= 72) checkOutput("rom_pos_idle", rom_pos, 0);
      if (fb_we) begin
        if (n_wr < exp_q.size()) begin
          checkOutput("fb_addr", fb_addr, exp_q[n_wr].addr);
          checkOutput("fb_data", fb_data, exp_q[n_wr].data);
        end
        if (first_addr < 0) first_addr = fb_addr;
        last_addr = fb_addr;
        if (fb_data) n_ones++;
        n_wr++;
      end
    end
    checkOutput("write_count_model", n_wr, exp_q.size());
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t vecs[6];
    int   n_wr, first_addr, last_addr, n_ones;
    vectors     = 0;
    miscompares = 0;
    char_valid  = 1'b0;
    char_in     = 8'd0;
    col_in      = 5'd0;
    row_in      = 3'd0;
    inv_in      = 1'b0;
    rst_n       = 1'b0;

    #2;
    checkOutput("reset_char_ready", char_ready, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_fb_we", fb_we, 0);
    checkOutput("reset_fb_addr", fb_addr, 0);
    checkOutput("reset_fb_data", fb_data, 0);
    checkOutput("reset_rom_pos", rom_pos, 0);
    checkOutput("reset_rom_char", rom_char, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs = '{
      '{8'h41, 5'd0,  3'd0, 1'b0, 72, 0,    1413, -1},
      '{8'h20, 5'd1,  3'd0, 1'b1, 72, 6,    1419, 72},
      '{8'h5A, 5'd20, 3'd4, 1'b0, 72, 6264, 7677, -1},
      '{8'h42, 5'd21, 3'd0, 1'b0, 0,  -1,   -1,   0},
      '{8'h43, 5'd0,  3'd5, 1'b1, 0,  -1,   -1,   0},
      '{8'h07, 5'd3,  3'd1, 1'b0, 72, 1554, 2967, 0}
    };

    $display("[TB] table vectors");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].c, vecs[i].col, vecs[i].row, vecs[i].inv);
      captureCell(vecs[i].c, vecs[i].col, vecs[i].row, vecs[i].inv, 1'b0, 8'd0, 5'd0,
                  n_wr, first_addr, last_addr, n_ones);
      checkOutput("table_count", n_wr, vecs[i].exp_count);
      checkOutput("table_first_addr", first_addr, vecs[i].exp_first);
      checkOutput("table_last_addr", last_addr, vecs[i].exp_last);
      if (vecs[i].exp_ones >= 0) checkOutput("table_ones", n_ones, vecs[i].exp_ones);
    end

    $display("[TB] random cells");
    for (int r = 0; r < 24; r++) begin
      logic [7:0] c;
      logic [4:0] cl;
      logic [2:0] rw;
      logic       iv;
      c  = 8'($urandom_range(0, 255));
      cl = 5'($urandom_range(0, 23));
      rw = 3'($urandom_range(0, 5));
      iv = 1'($urandom_range(0, 1));
      applyStimulus(c, cl, rw, iv);
      captureCell(c, cl, rw, iv, 1'b0, 8'd0, 5'd0, n_wr, first_addr, last_addr, n_ones);
    end

    $display("[TB] back-to-back with valid held");
    applyStimulus(8'h48, 5'd2, 3'd1, 1'b0);
    captureCell(8'h48, 5'd2, 3'd1, 1'b0, 1'b1, 8'h51, 5'd7, n_wr, first_addr, last_addr, n_ones);
    checkOutput("b2b_first_count", n_wr, 72);
    checkOutput("b2b_first_addr", first_addr, 12 * 128 + 12);
    captureCell(8'h51, 5'd7, 3'd1, 1'b0, 1'b0, 8'd0, 5'd0, n_wr, first_addr, last_addr, n_ones);
    checkOutput("b2b_second_count", n_wr, 72);
    checkOutput("b2b_second_first_addr", first_addr, 12 * 128 + 42);

    $display("[TB] reset mid-render");
    applyStimulus(8'h4D, 5'd3, 3'd2, 1'b0);
    n_wr = 0;
    for (int k = 0; k < 100 && n_wr < 30; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) char_valid = 1'b0;
      if (fb_we) n_wr++;
    end
    checkOutput("writes_before_reset", n_wr, 30);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_fb_we", fb_we, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_rom_pos", rom_pos, 0);
    checkOutput("rst_char_ready", char_ready, 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      checkOutput("post_rst_done", done, 0);
      checkOutput("post_rst_busy", busy, 0);
      checkOutput("post_rst_ready", char_ready, 1);
    end
    applyStimulus(8'h4D, 5'd3, 3'd2, 1'b0);
    captureCell(8'h4D, 5'd3, 3'd2, 1'b0, 1'b0, 8'd0, 5'd0, n_wr, first_addr, last_addr, n_ones);
    checkOutput("post_rst_count", n_wr, 72);
    checkOutput("post_rst_first_addr", first_addr, 24 * 128 + 18);
    checkOutput("post_rst_last_addr", last_addr, 35 * 128 + 23);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
